// File: rtl/systolic_result_drain.sv
// Result drain for the systolic array: snapshots all accumulators on start and
// streams them out row-major over valid/ready, pulsing acc_clr back to the array.
module systolic_result_drain #(
  parameter int N   = 32,
  parameter int DIM = 5,
  parameter int M   = 25
) (
  input  logic           clk,
  input  logic           init_n,
  input  logic           start,
  input  logic [N*M-1:0] c_flat,
  output logic           acc_clr,
  output logic           busy,
  output logic           out_valid,
  input  logic           out_ready,
  output logic [N-1:0]   out_data,
  output logic [2:0]     out_row,
  output logic [2:0]     out_col,
  output logic           out_last,
  output logic           done
);

  localparam int RW = (DIM > 1) ? $clog2(DIM) : 1;
  localparam int IW = (M > 1) ? $clog2(M) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_STREAM,
    S_DONE
  } state_t;

  state_t        r_state;
  state_t        w_next;
  logic [N-1:0]  r_buf [M];
  logic [RW-1:0] r_row;
  logic [RW-1:0] r_col;
  logic          r_acc_clr;
  logic [IW-1:0] w_idx;
  logic          w_last;
  logic          w_xfer;
  logic          w_accept;

  assign w_idx    = IW'(r_row) * IW'(DIM) + IW'(r_col);
  assign w_last   = (r_row == RW'(DIM - 1)) && (r_col == RW'(DIM - 1));
  assign w_xfer   = (r_state == S_STREAM) && out_ready;
  assign w_accept = (r_state == S_IDLE) && start;

  always_comb begin
    w_next = r_state;
    unique case (r_state)
      S_IDLE:   if (start) w_next = S_STREAM;
      S_STREAM: if (out_ready && w_last) w_next = S_DONE;
      S_DONE:   w_next = S_IDLE;
      default:  w_next = S_IDLE;
    endcase
  end

  always_comb begin
    busy      = 1'b0;
    out_valid = 1'b0;
    done      = 1'b0;
    out_data  = '0;
    out_row   = '0;
    out_col   = '0;
    out_last  = 1'b0;
    acc_clr   = r_acc_clr;
    unique case (r_state)
      S_IDLE: ;
      S_STREAM: begin
        busy      = 1'b1;
        out_valid = 1'b1;
        out_data  = r_buf[w_idx];
        out_row   = 3'(r_row);
        out_col   = 3'(r_col);
        out_last  = w_last;
      end
      S_DONE: begin
        busy = 1'b1;
        done = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_state   <= S_IDLE;
      r_acc_clr <= 1'b0;
    end else begin
      r_state   <= w_next;
      r_acc_clr <= w_accept;
    end
  end

  // Index returns to 0 on the final transfer so the next tile starts clean.
  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_accept) begin
      r_row <= '0;
      r_col <= '0;
    end else if (w_xfer) begin
      if (w_last) begin
        r_row <= '0;
        r_col <= '0;
      end else if (r_col == RW'(DIM - 1)) begin
        r_col <= '0;
        r_row <= r_row + 1'b1;
      end else begin
        r_col <= r_col + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge init_n) begin
    if (!init_n) begin
      for (int unsigned i = 0; i < M; i++) r_buf[i] <= '0;
    end else if (w_accept) begin
      for (int unsigned i = 0; i < M; i++) r_buf[i] <= c_flat[i*N +: N];
    end
  end

endmodule

// File: tb/tb_systolic_result_drain.sv
// Directed bench for systolic_result_drain: drain order, backpressure, snapshot
// isolation, start filtering, reset abort and back-to-back tiles.
module tb_systolic_result_drain;
  localparam int N   = 32;
  localparam int DIM = 5;
  localparam int M   = 25;

  logic           clk = 1'b0;
  logic           init_n;
  logic           start;
  logic [N*M-1:0] c_flat;
  logic           acc_clr, busy, out_valid, out_ready, out_last, done;
  logic [N-1:0]   out_data;
  logic [2:0]     out_row, out_col;

  int n_cmp = 0;
  int n_err = 0;

  localparam logic [42:0] DONE_V = {1'b1, 1'b0, 1'b0, 1'b1, 1'b0, 3'd0, 3'd0, 32'd0};

  systolic_result_drain #(.N(N), .DIM(DIM), .M(M)) dut (
    .clk(clk), .init_n(init_n), .start(start), .c_flat(c_flat),
    .acc_clr(acc_clr), .busy(busy), .out_valid(out_valid), .out_ready(out_ready),
    .out_data(out_data), .out_row(out_row), .out_col(out_col),
    .out_last(out_last), .done(done)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

  function automatic logic [42:0] obs();
    return {busy, out_valid, acc_clr, done, out_last, out_row, out_col, out_data};
  endfunction

  // Expected observation for word i of a tile whose C[r][c] = base + 10*r + c.
  function automatic logic [42:0] ew(input logic [31:0] base, input int i, input logic acc);
    logic [31:0] w;
    w = base + 32'(10 * (i / DIM) + (i % DIM));
    return {1'b1, 1'b1, acc, 1'b0, (i == M - 1), 3'(i / DIM), 3'(i % DIM), w};
  endfunction

  task automatic load(input logic [31:0] base);
    for (int r = 0; r < DIM; r++)
      for (int c = 0; c < DIM; c++)
        c_flat[(r*DIM+c)*N +: N] = base + 32'(10 * r + c);
  endtask

  task automatic test_reset;
    init_n = 1'b0; start = 1'b1; out_ready = 1'b1; load(32'h0);
    repeat (3) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== 43'd0) begin
        n_err++; $display("FAIL reset: got %h expected %h", obs(), 43'd0);
      end
    end
    start = 1'b0; init_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== 43'd0) begin
      n_err++; $display("FAIL idle_after_reset: got %h expected %h", obs(), 43'd0);
    end
  endtask

  task automatic test_basic_drain;
    load(32'h0); out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < M; i++) begin
      n_cmp++;
      if (obs() !== ew(32'h0, i, i == 0)) begin
        n_err++; $display("FAIL basic_word[%0d]: got %h expected %h", i, obs(), ew(32'h0, i, i == 0));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== DONE_V) begin
      n_err++; $display("FAIL basic_done: got %h expected %h", obs(), DONE_V);
    end
    @(negedge clk);
    n_cmp++;
    if (obs() !== 43'd0) begin
      n_err++; $display("FAIL basic_idle: got %h expected %h", obs(), 43'd0);
    end
  endtask

  task automatic test_backpressure;
    int i, t;
    logic rdy;
    load(32'h0); start = 1'b1;
    @(negedge clk); start = 1'b0;
    i = 0; t = 0;
    while (i < M && t < 200) begin
      rdy = (t % 4 == 0) || (t % 4 == 3);
      out_ready = rdy;
      n_cmp++;
      if (obs() !== ew(32'h0, i, t == 0)) begin
        n_err++; $display("FAIL bp_word[%0d] t=%0d: got %h expected %h", i, t, obs(), ew(32'h0, i, t == 0));
      end
      @(negedge clk);
      if (rdy) i++;
      t++;
    end
    n_cmp++;
    if (i != M) begin
      n_err++; $display("FAIL bp_count: got %0d expected %0d", i, M);
    end
    out_ready = 1'b1;
    n_cmp++;
    if (obs() !== DONE_V) begin
      n_err++; $display("FAIL bp_done: got %h expected %h", obs(), DONE_V);
    end
    @(negedge clk);
  endtask

  task automatic test_snapshot;
    load(32'h1000); out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    c_flat = '1;
    for (int i = 0; i < M; i++) begin
      n_cmp++;
      if (obs() !== ew(32'h1000, i, i == 0)) begin
        n_err++; $display("FAIL snap_word[%0d]: got %h expected %h", i, obs(), ew(32'h1000, i, i == 0));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== DONE_V) begin
      n_err++; $display("FAIL snap_done: got %h expected %h", obs(), DONE_V);
    end
    @(negedge clk);
  endtask

  task automatic test_start_while_busy;
    int k;
    load(32'h2000); out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    load(32'h3000);
    for (int i = 0; i < M; i++) begin
      n_cmp++;
      if (obs() !== ew(32'h2000, i, i == 0)) begin
        n_err++; $display("FAIL swb_word[%0d]: got %h expected %h", i, obs(), ew(32'h2000, i, i == 0));
      end
      start = (i == 5) || (i == 24);
      @(negedge clk);
    end
    start = 1'b1;
    n_cmp++;
    if (obs() !== DONE_V) begin
      n_err++; $display("FAIL swb_done: got %h expected %h", obs(), DONE_V);
    end
    @(negedge clk);
    n_cmp++;
    if (obs() !== 43'd0) begin
      n_err++; $display("FAIL swb_ignored_in_done: got %h expected %h", obs(), 43'd0);
    end
    @(negedge clk); start = 1'b0;
    n_cmp++;
    if (obs() !== ew(32'h3000, 0, 1'b1)) begin
      n_err++; $display("FAIL swb_restart: got %h expected %h", obs(), ew(32'h3000, 0, 1'b1));
    end
    k = 0;
    while (!done && k < 100) begin
      @(negedge clk); k++;
    end
    n_cmp++;
    if (k != M) begin
      n_err++; $display("FAIL swb_restart_len: got %0d expected %0d", k, M);
    end
    @(negedge clk);
  endtask

  task automatic test_reset_mid_stream;
    load(32'h4000); out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i <= 12; i++) begin
      n_cmp++;
      if (obs() !== ew(32'h4000, i, i == 0)) begin
        n_err++; $display("FAIL rst_word[%0d]: got %h expected %h", i, obs(), ew(32'h4000, i, i == 0));
      end
      if (i < 12) @(negedge clk);
    end
    #2 init_n = 1'b0;
    #1;
    n_cmp++;
    if (obs() !== 43'd0) begin
      n_err++; $display("FAIL rst_async: got %h expected %h", obs(), 43'd0);
    end
    repeat (2) begin
      @(negedge clk);
      n_cmp++;
      if (obs() !== 43'd0) begin
        n_err++; $display("FAIL rst_hold: got %h expected %h", obs(), 43'd0);
      end
    end
    init_n = 1'b1;
    @(negedge clk);
    n_cmp++;
    if (obs() !== 43'd0) begin
      n_err++; $display("FAIL rst_no_done: got %h expected %h", obs(), 43'd0);
    end
    load(32'h5000); start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int i = 0; i < M; i++) begin
      n_cmp++;
      if (obs() !== ew(32'h5000, i, i == 0)) begin
        n_err++; $display("FAIL rst_redrain[%0d]: got %h expected %h", i, obs(), ew(32'h5000, i, i == 0));
      end
      @(negedge clk);
    end
    n_cmp++;
    if (obs() !== DONE_V) begin
      n_err++; $display("FAIL rst_redrain_done: got %h expected %h", obs(), DONE_V);
    end
    @(negedge clk);
  endtask

  task automatic test_back_to_back;
    logic [42:0] e;
    int d0, d1;
    d0 = -1; d1 = -1;
    load(32'h6000); out_ready = 1'b1; start = 1'b1;
    @(negedge clk); start = 1'b0;
    for (int s = 0; s < 2 * M + 4; s++) begin
      if (s < M)              e = ew(32'h6000, s, s == 0);
      else if (s == M)        e = DONE_V;
      else if (s == M + 1)    e = 43'd0;
      else if (s < 2 * M + 2) e = ew(32'h7000, s - M - 2, s == M + 2);
      else if (s == 2 * M + 2) e = DONE_V;
      else                    e = 43'd0;
      n_cmp++;
      if (obs() !== e) begin
        n_err++; $display("FAIL b2b[%0d]: got %h expected %h", s, obs(), e);
      end
      if (done) begin
        if (d0 < 0) d0 = s; else d1 = s;
      end
      start = (s == M + 1);
      if (s == M + 1) load(32'h7000);
      @(negedge clk);
    end
    n_cmp++;
    if (d1 - d0 != M + 2) begin
      n_err++; $display("FAIL b2b_done_gap: got %0d expected %0d", d1 - d0, M + 2);
    end
  endtask

  initial begin
    init_n = 1'b0; start = 1'b0; out_ready = 1'b0; c_flat = '0;
    @(negedge clk);
    test_reset();
    test_basic_drain();
    test_backpressure();
    test_snapshot();
    test_start_while_busy();
    test_reset_mid_stream();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
